// File: rtl/hazard_control.sv
// hazard_control: stall/flush/freeze controller for a 5-stage MIPS-style pipe.
// Ports: clk, rst_n (sync, active-low); ifid_reg/idex_reg instruction words;
//   dmem_req/dmem_ready MEM-stage handshake; branch_taken from EX.
//   Outputs: per-register write enables, IF/ID and ID/EX flushes,
//   sticky mem_timeout, saturating stall_count/flush_count.
module hazard_control #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      ifid_reg,
    input  logic [159:0]     idex_reg,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwr_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int WAIT_W =
        (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              wait_expired;

    logic [5:0] ifid_op;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic [5:0] idex_op;
    logic [4:0] idex_rt;

    logic idex_is_load;
    logic ifid_uses_rt;
    logic load_use;
    logic mem_stall;

    logic ev_reset;
    logic ev_freeze;
    logic ev_flush;
    logic ev_bubble;
    logic ev_normal;

    logic unused_bits;

    assign ifid_op = ifid_reg[31:26];
    assign ifid_rs = ifid_reg[25:21];
    assign ifid_rt = ifid_reg[20:16];
    assign idex_op = idex_reg[31:26];
    assign idex_rt = idex_reg[20:16];

    // Only the opcode and register fields matter here.
    assign unused_bits = ^{ifid_reg[63:32], ifid_reg[15:0],
                           idex_reg[159:32], idex_reg[25:21],
                           idex_reg[15:0]};

    always_comb begin
        idex_is_load = 1'b0;
        unique case (idex_op)
            OP_LW, OP_LB, OP_LBU: idex_is_load = 1'b1;
            default:              idex_is_load = 1'b0;
        endcase
    end

    // Opcodes whose rt field is a source operand, not a destination.
    always_comb begin
        ifid_uses_rt = 1'b0;
        unique case (ifid_op)
            OP_RTYPE, OP_SW, OP_SB,
            OP_BEQ, OP_BNE:   ifid_uses_rt = 1'b1;
            default:          ifid_uses_rt = 1'b0;
        endcase
    end

    assign load_use = idex_is_load
                   && (idex_rt != 5'd0)
                   && ((ifid_rs == idex_rt)
                    || (ifid_uses_rt && (ifid_rt == idex_rt)));

    // Once waiting, only dmem_ready releases the pipe; dmem_req is ignored.
    always_comb begin
        mem_stall = 1'b0;
        state_nxt = state;
        unique case (state)
            RUN: begin
                mem_stall = dmem_req && !dmem_ready;
                state_nxt = mem_stall ? MEM_WAIT : RUN;
            end
            MEM_WAIT: begin
                mem_stall = !dmem_ready;
                state_nxt = dmem_ready ? RUN : MEM_WAIT;
            end
            default: begin
                mem_stall = 1'b0;
                state_nxt = RUN;
            end
        endcase
    end

    // Mutually exclusive event decode in priority order.
    assign ev_reset  = !rst_n;
    assign ev_freeze = rst_n && mem_stall;
    assign ev_flush  = rst_n && !mem_stall && branch_taken;
    assign ev_bubble = rst_n && !mem_stall && !branch_taken
                    && load_use;
    assign ev_normal = rst_n && !mem_stall && !branch_taken
                    && !load_use;

    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_we    = 1'b0;
        exmem_we   = 1'b0;
        memwr_we   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        unique case (1'b1)
            ev_reset: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            ev_freeze: begin
                pc_we = 1'b0;
            end
            ev_flush: begin
                pc_we      = 1'b1;
                ifid_we    = 1'b1;
                idex_we    = 1'b1;
                exmem_we   = 1'b1;
                memwr_we   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            ev_bubble: begin
                idex_we    = 1'b1;
                exmem_we   = 1'b1;
                memwr_we   = 1'b1;
                idex_flush = 1'b1;
            end
            ev_normal: begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
                memwr_we = 1'b1;
            end
            default: begin
                pc_we = 1'b0;
            end
        endcase
    end

    assign wait_cnt_nxt = (wait_cnt == WAIT_MAX)
                        ? wait_cnt
                        : wait_cnt + WAIT_W'(1);

    // Only a wait that is still unanswered can expire.
    assign wait_expired = (state == MEM_WAIT) && !dmem_ready
                       && (wait_cnt_nxt == WAIT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            // Held at zero in RUN so each MEM_WAIT entry starts fresh.
            if (state == RUN) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt_nxt;
            end
            if (wait_expired) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if ((ev_freeze || ev_bubble)
                && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (ev_flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule
